subservient_sram_arb: RTL and testbench
=======================================

SUBSERVIENT_SRAM_ARB -- requirements
Module: subservient_sram_arb

Interface
REQ-001 Parameters SHALL be: depth, default 512, SRAM depth in bytes; aw, default $clog2(depth), byte address width; rf_base, default depth-144, first byte of the register-file region.
REQ-002 Ports SHALL be (clock and reset first):
 i_clk  in  1  clock
 i_rst  in  1  reset, synchronous, active-high
 i_rf_waddr  in  8  RF write byte address, 0..143
 i_rf_wdata  in  8  RF write data
 i_rf_wen  in  1  RF write strobe
 i_rf_raddr  in  8  RF read byte address
 i_rf_ren  in  1  RF read strobe
 o_rf_rdata  out  8  RF read data
 i_wb_adr  in  aw-2  wishbone word address
 i_wb_dat  in  32  wishbone write data
 i_wb_sel  in  4  byte selects
 i_wb_we  in  1  write enable
 i_wb_stb  in  1  strobe, held until ack
 o_wb_rdt  out  32  read data
 o_wb_ack  out  1  single-cycle ack
 o_sram_waddr  out  aw  SRAM write address
 o_sram_wdata  out  8  SRAM write data
 o_sram_wen  out  1  SRAM write enable
 o_sram_raddr  out  aw  SRAM read address
 o_sram_ren  out  1  SRAM read enable
 i_sram_rdata  in  8  SRAM read data, valid the cycle after o_sram_ren

Function
REQ-003 The RF side SHALL have absolute priority on each port; RF strobes pass combinationally to the SRAM with address rf_base+i_rf_*addr.
REQ-004 o_rf_rdata SHALL equal i_sram_rdata unmodified.
REQ-005 The wishbone side SHALL use a port only in cycles where the corresponding RF strobe is low.
REQ-006 States SHALL be IDLE, XFER, ACK; IDLE->XFER on i_wb_stb; XFER->ACK after all 4 byte slots complete (reads: after last byte captured); ACK->IDLE unconditionally.
REQ-007 In XFER a 2-bit byte counter SHALL issue bytes 0..3 at SRAM address {i_wb_adr,cnt}, advancing only when the needed port is free.
REQ-008 Write slots with i_wb_sel[cnt]=0 SHALL advance the counter without asserting o_sram_wen.
REQ-009 Read byte k SHALL be captured into o_wb_rdt[8k+7:8k] from i_sram_rdata in the cycle after it is issued; the read path SHALL track a one-bit pending flag.
REQ-010 o_wb_ack SHALL be high exactly one cycle (state ACK); i_wb_stb SHALL be ignored in ACK.
REQ-011 With no RF activity and i_wb_stb rising in cycle N: write ack in N+5, read ack in N+6 with o_wb_rdt valid.
REQ-012 RF strobes colliding with a pending slot SHALL stall that slot one cycle per colliding cycle; no byte is lost or duplicated.
REQ-013 o_wb_rdt SHALL hold its value until the next wishbone read updates it.

Reset
REQ-014 i_rst SHALL force state IDLE, counter 0, pending 0, o_wb_ack 0, o_wb_rdt 0; i_rst mid-transfer SHALL abort it with no ack.
REQ-015 SRAM strobes from the wishbone side SHALL be 0 during reset; RF pass-through SHALL remain combinational.

Configuration
REQ-016 With SUBSERVIENT_SRAM_ARB_PROTECT_EN defined, wishbone accesses whose byte address is >= rf_base SHALL skip XFER: writes discarded, reads return 0, ack one cycle after IDLE sees stb.
REQ-017 Without SUBSERVIENT_SRAM_ARB_PROTECT_EN, the RF region SHALL be accessible like any other address.

Structure
REQ-018 Package subservient_pkg SHALL hold RF_REGS=36, RF_BYTES=144 and the state enum.
REQ-019 The block SHALL be a single module; no sub-module.

Verification
REQ-020 Write adr=0x10, dat=0xAABBCCDD, sel=4'hF, RF idle -> wen at byte addresses 0x40..0x43 with data DD,CC,BB,AA; ack in N+5.
REQ-021 Read of that word, RF idle -> o_wb_rdt=0xAABBCCDD, ack in N+6.
REQ-022 Write sel=4'b0101 dat=0x11223344 over 0xAABBCCDD -> read back 0xAA22CC44.
REQ-023 Read with i_rf_ren high for 3 cycles during XFER -> ack delayed exactly 3 cycles, data correct, RF reads bypass unchanged.
REQ-024 i_rst asserted in XFER after byte 1 -> no ack, state IDLE, next transfer completes normally.
REQ-025 PROTECT_EN defined: write to rf_base -> no SRAM wen, ack in N+1; read -> o_wb_rdt=0.

Source files
------------

// File: rtl/subservient_pkg.sv
// Shared constants and the arbiter state type for the subservient SRAM arbiter.
package subservient_pkg;

  localparam int RF_REGS  = 36;
  localparam int RF_BYTES = 144;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/subservient_sram_arb.sv
// Shares one byte-wide SRAM between the register file (absolute priority) and a 32-bit wishbone port.
// Optional: SUBSERVIENT_SRAM_ARB_PROTECT_EN blocks wishbone access to the register-file region.
module subservient_sram_arb
  import subservient_pkg::*;
#(
  parameter int depth   = 512,
  parameter int aw      = $clog2(depth),
  parameter int rf_base = depth - RF_BYTES
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_rf_waddr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_wen,
  input  logic [7:0]    i_rf_raddr,
  input  logic          i_rf_ren,
  output logic [7:0]    o_rf_rdata,
  input  logic [aw-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  localparam logic [aw-1:0] RF_BASE_A = aw'(rf_base);

  // Handshake: i_wb_stb is held by the master until o_wb_ack, which is a
  // single-cycle pulse; i_wb_stb seen during ACK starts nothing.
  state_e     state;
  logic [1:0] cnt;
  logic [1:0] pend_idx;
  logic       pending;
  logic       issued_all;
  logic       wb_slot;
  logic       wr_need;
  logic       wb_wen;
  logic       wr_go;
  logic       rd_go;
  logic       rd_last;
  logic [7:0] wb_byte;

  assign wb_slot  = (state == ST_XFER) && !i_rst;
  assign wr_need  = i_wb_sel[cnt];
  assign wb_byte  = i_wb_dat[{cnt, 3'b000} +: 8];
  assign pend_idx = cnt - 2'd1;

  // A deselected write slot needs no port, so it never waits on the RF.
  assign wb_wen  = wb_slot && i_wb_we && wr_need && !i_rf_wen;
  assign wr_go   = wb_slot && i_wb_we && (!wr_need || !i_rf_wen);
  assign rd_go   = wb_slot && !i_wb_we && !issued_all && !i_rf_ren;
  assign rd_last = wb_slot && !i_wb_we && pending && issued_all;

  assign o_sram_wen   = i_rf_wen | wb_wen;
  assign o_sram_waddr = i_rf_wen ? (RF_BASE_A + aw'(i_rf_waddr)) : {i_wb_adr, cnt};
  assign o_sram_wdata = i_rf_wen ? i_rf_wdata : wb_byte;
  assign o_sram_ren   = i_rf_ren | rd_go;
  assign o_sram_raddr = i_rf_ren ? (RF_BASE_A + aw'(i_rf_raddr)) : {i_wb_adr, cnt};
  assign o_rf_rdata   = i_sram_rdata;
  assign o_wb_ack     = (state == ST_ACK) && !i_rst;

`ifdef SUBSERVIENT_SRAM_ARB_PROTECT_EN
  logic prot_hit;
  assign prot_hit = {i_wb_adr, 2'b00} >= RF_BASE_A;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      pending    <= 1'b0;
      issued_all <= 1'b0;
      o_wb_rdt   <= 32'd0;
    end else begin
      // The byte issued last cycle is the one just behind the counter.
      pending <= rd_go;
      if (pending) o_wb_rdt[{pend_idx, 3'b000} +: 8] <= i_sram_rdata;
      case (state)
        ST_IDLE: begin
          cnt        <= 2'd0;
          issued_all <= 1'b0;
          if (i_wb_stb) begin
`ifdef SUBSERVIENT_SRAM_ARB_PROTECT_EN
            if (prot_hit) begin
              state <= ST_ACK;
              if (!i_wb_we) o_wb_rdt <= 32'd0;
            end else begin
              state <= ST_XFER;
            end
`else
            state <= ST_XFER;
`endif
          end
        end
        ST_XFER: begin
          if (wr_go || rd_go) cnt <= cnt + 2'd1;
          if (rd_go && (cnt == 2'd3)) issued_all <= 1'b1;
          if ((wr_go && (cnt == 2'd3)) || rd_last) state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Bench for subservient_sram_arb: byte-array memory model, word-level expected queue, random RF traffic.
module tb_subservient_sram_arb;
  import subservient_pkg::*;

  localparam int DEPTH   = 512;
  localparam int AW      = 9;
  localparam int RF_BASE = DEPTH - 144;

  logic          clk;
  logic          rst;
  logic [7:0]    rf_waddr, rf_wdata, rf_raddr, rf_rdata;
  logic          rf_wen, rf_ren;
  logic [AW-3:0] wb_adr;
  logic [31:0]   wb_dat, wb_rdt;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_stb, wb_ack;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [7:0]    sram_wdata, sram_rdata;
  logic          sram_wen, sram_ren;

  int n_vec = 0;
  int n_err = 0;
  int wb_wen_cnt = 0;
  bit wb_done;
  bit mem_clear;

  logic [7:0]  sram    [DEPTH];
  logic [7:0]  exp_mem [DEPTH];
  logic [31:0] exp_q[$];

  subservient_sram_arb dut (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
    .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
    .o_sram_raddr(sram_raddr), .o_sram_ren(sram_ren), .i_sram_rdata(sram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous byte SRAM, read data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 8'd0;
      sram_rdata <= 8'd0;
    end else begin
      if (sram_wen) sram[sram_waddr] <= sram_wdata;
      if (sram_ren) sram_rdata <= sram[sram_raddr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RF pass-through and reset-time strobe monitor
  always @(negedge clk) begin
    check("rf_rdata", rf_rdata, sram_rdata);
    if (rf_wen)
      check("rf_wr_pass", {sram_wen, sram_waddr, sram_wdata},
            {1'b1, AW'(RF_BASE + int'(rf_waddr)), rf_wdata});
    if (rf_ren)
      check("rf_rd_pass", {sram_ren, sram_raddr}, {1'b1, AW'(RF_BASE + int'(rf_raddr))});
    if (rst) check("rst_strobe", {sram_wen, sram_ren}, {rf_wen, rf_ren});
    if (sram_wen && !rf_wen) wb_wen_cnt++;
  end

  function automatic bit prot(input logic [AW-3:0] adr);
`ifdef SUBSERVIENT_SRAM_ARB_PROTECT_EN
    return (int'(adr) * 4) >= RF_BASE;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-3:0] adr);
    int b;
    b = int'(adr) * 4;
    return {exp_mem[b+3], exp_mem[b+2], exp_mem[b+1], exp_mem[b]};
  endfunction

  // driver: one wishbone access; latency counted in cycles from the stb cycle
  task automatic wb_xfer(input logic we, input logic [AW-3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat, output logic [31:0] rdt);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_stb = 1'b1;
    cyc = 0; seen = 1'b0; lat = -1; rdt = '0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (wb_ack) begin
        seen = 1'b1;
        lat = cyc;
        rdt = wb_rdt;
      end else begin
        cyc++;
      end
    end
    check("ack_seen", seen, 1'b1);
    @(posedge clk); #1;
    wb_stb = 1'b0;
    @(negedge clk);
    check("ack_pulse", wb_ack, 1'b0);
  endtask

  task automatic do_write(input logic [AW-3:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int exp_lat);
    int lat;
    logic [31:0] rdt;
    wb_xfer(1'b1, adr, dat, sel, lat, rdt);
    if (exp_lat >= 0) check("wr_lat", lat, exp_lat);
    if (!prot(adr))
      for (int k = 0; k < 4; k++)
        if (sel[k]) exp_mem[int'(adr) * 4 + k] = dat[8*k +: 8];
    wb_done = 1'b1;
  endtask

  task automatic do_read(input logic [AW-3:0] adr, input int exp_lat, output logic [31:0] got);
    int lat;
    logic [31:0] exp;
    exp_q.push_back(prot(adr) ? 32'd0 : mem_word(adr));
    wb_xfer(1'b0, adr, 32'd0, 4'h0, lat, got);
    if (exp_lat >= 0) check("rd_lat", lat, exp_lat);
    exp = exp_q.pop_front();
    check("rd_data", got, exp);
    wb_done = 1'b1;
  endtask

  // random RF traffic until the concurrent wishbone access finishes
  task automatic rf_random();
    while (!wb_done) begin
      @(posedge clk); #1;
      if (wb_done) break;
      rf_wen   = ($urandom_range(0, 2) == 0);
      rf_waddr = 8'($urandom_range(0, 143));
      rf_wdata = 8'($urandom);
      rf_ren   = ($urandom_range(0, 2) == 0);
      rf_raddr = 8'($urandom_range(0, 143));
      if (rf_wen) exp_mem[RF_BASE + int'(rf_waddr)] = rf_wdata;
    end
    rf_wen = 1'b0;
    rf_ren = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [AW-3:0] radr;
    logic [31:0] rdat;
    logic [3:0] rsel;
    int snap;

    rst = 1'b1; mem_clear = 1'b1; wb_done = 1'b0;
    rf_wen = 1'b0; rf_ren = 1'b0; rf_waddr = '0; rf_raddr = '0; rf_wdata = '0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", wb_ack, 1'b0);
    check("rst_rdt", wb_rdt, 32'd0);
    check("rst_state", dut.state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0; mem_clear = 1'b0;

    // plain word write / read-back, RF idle
    do_write(7'h10, 32'hAABBCCDD, 4'hF, 5);
    check("sram_40_43", {sram[9'h43], sram[9'h42], sram[9'h41], sram[9'h40]}, 32'hAABBCCDD);
    do_read(7'h10, 6, got);
    check("rd_word", got, 32'hAABBCCDD);

    // partial write keeps unselected bytes; rdt holds across a write
    do_write(7'h10, 32'h11223344, 4'b0101, 5);
    check("rdt_hold", wb_rdt, 32'hAABBCCDD);
    do_read(7'h10, 6, got);
    check("rd_masked", got, 32'hAA22CC44);

    // three RF read cycles during the transfer stall it by exactly three
    fork
      do_read(7'h10, 9, got);
      begin
        repeat (3) @(posedge clk); #1;
        rf_ren = 1'b1; rf_raddr = 8'd5;
        repeat (3) @(posedge clk); #1;
        rf_ren = 1'b0;
      end
    join
    check("rd_stall_word", got, 32'hAA22CC44);

    // register-file region through wishbone
    snap = wb_wen_cnt;
`ifdef SUBSERVIENT_SRAM_ARB_PROTECT_EN
    do_write(7'(RF_BASE / 4), 32'h55667788, 4'hF, 1);
    check("prot_no_wen", wb_wen_cnt, snap);
    check("prot_sram", sram[RF_BASE], 8'd0);
    do_read(7'(RF_BASE / 4), 1, got);
    check("prot_rd_zero", got, 32'd0);
`else
    do_write(7'(RF_BASE / 4), 32'h55667788, 4'hF, 5);
    check("rfreg_wen", wb_wen_cnt, snap + 4);
    do_read(7'(RF_BASE / 4), 6, got);
    check("rfreg_rd", got, 32'h55667788);
`endif

    // reset after byte 1 of a read: no ack, back to idle, next access normal
    @(posedge clk); #1;
    wb_we = 1'b0; wb_adr = 7'h10; wb_sel = 4'hF; wb_stb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", wb_ack, 1'b0);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_no_ack", wb_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check("abort_state", dut.state, ST_IDLE);
    check("abort_rdt", wb_rdt, 32'd0);
    check("abort_no_ack", wb_ack, 1'b0);
    do_write(7'h20, 32'hDEADBEEF, 4'hF, 5);
    do_read(7'h20, 6, got);

    // random accesses against random RF traffic
    for (int i = 0; i < 40; i++) begin
      radr = 7'($urandom_range(0, 15));
      rdat = $urandom;
      rsel = 4'($urandom);
      wb_done = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        fork
          do_write(radr, rdat, rsel, -1);
          rf_random();
        join
      end else begin
        fork
          do_read(radr, -1, got);
          rf_random();
        join
      end
    end

    // final sweep through wishbone with the RF quiet
    for (int a = 0; a < 16; a++) begin
      do_read(7'(a), 6, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
